// File: rtl/debug_mem_arbiter_pkg.sv
// Shared types and default sizes for the debug memory arbiter.
// Holds the arbiter FSM state and grant enums, plus a small helper that
// resolves a tie between the two requesters using round-robin order.
package debug_mem_arbiter_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_PROT_BASE = 'hC0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_RD  = 2'd1,
    JTAG_RD = 2'd2
  } arbState_e;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_JTAG = 1'b1
  } grant_e;

  // On a tie the requester that did not win last time gets the RAM.
  function automatic grant_e tieWinner(input grant_e lastGrant);
    return (lastGrant == GNT_CPU) ? GNT_JTAG : GNT_CPU;
  endfunction

endpackage

// File: rtl/debug_mem_jtag_cmd_latch.sv
// JTAG command latch for the debug memory arbiter.
// Resolves strobe priority (set_addr > wr > rd), holds the single
// outstanding JTAG command, keeps the auto-incrementing JTAG address and
// the sticky overflow flag for strobes that could not be accepted.
module debug_mem_jtag_cmd_latch
  import debug_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_setAddr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_clrOvf,
  input  logic              i_cmdDone,
  output logic [ADDR_W-1:0] o_jaddr,
  output logic              o_jpend,
  output logic              o_jopRd,
  output logic [DATA_W-1:0] o_jwdata,
  output logic              o_ovf
);

  logic [ADDR_W-1:0] r_jaddr;
  logic              r_jpend;
  logic              r_jopRd;
  logic [DATA_W-1:0] r_jwdata;
  logic              r_ovf;

  logic w_anyStrobe;
  logic w_multiStrobe;
  logic w_drop;
  logic w_takeSet;
  logic w_takeWr;
  logic w_takeRd;

  // Pick the highest-priority strobe; everything else this cycle is a drop.
  always_comb begin
    w_anyStrobe   = i_setAddr | i_wr | i_rd;
    w_multiStrobe = (i_setAddr & (i_wr | i_rd)) | (i_wr & i_rd);
    w_takeSet     = 1'b0;
    w_takeWr      = 1'b0;
    w_takeRd      = 1'b0;
    w_drop        = 1'b0;
    if (r_jpend) begin
      w_drop = w_anyStrobe;
    end else begin
      w_drop    = w_multiStrobe;
      w_takeSet = i_setAddr;
      w_takeWr  = ~i_setAddr & i_wr;
      w_takeRd  = ~i_setAddr & ~i_wr & i_rd;
    end
  end

  // JTAG address: loaded by set_addr, bumped (with wrap) when a RAM access finishes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_jaddr <= '0;
    end else if (w_takeSet) begin
      r_jaddr <= i_addr;
    end else if (i_cmdDone) begin
      r_jaddr <= r_jaddr + ADDR_W'(1);
    end
  end

  // Pending command: captured from wr/rd, released once the arbiter completes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_jpend  <= 1'b0;
      r_jopRd  <= 1'b0;
      r_jwdata <= '0;
    end else if (w_takeWr || w_takeRd) begin
      r_jpend <= 1'b1;
      r_jopRd <= w_takeRd;
      if (w_takeWr) begin
        r_jwdata <= i_wdata;
      end
    end else if (i_cmdDone) begin
      r_jpend <= 1'b0;
    end
  end

  // Sticky overflow: a fresh drop wins over a simultaneous clear request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (i_clrOvf) begin
      r_ovf <= 1'b0;
    end
  end

  assign o_jaddr  = r_jaddr;
  assign o_jpend  = r_jpend;
  assign o_jopRd  = r_jopRd;
  assign o_jwdata = r_jwdata;
  assign o_ovf    = r_ovf;

endmodule

// File: rtl/debug_mem_arbiter.sv
// Debug memory arbiter: shares one single-port debug RAM between JTAG debug
// commands and the CPU Avalon-MM slave port with round-robin arbitration.
// Optional CPU write protection above PROT_BASE is enabled by defining
// DEBUG_MEM_ARBITER_WRPROT_EN, which also adds the cpu_wr_err output.
module debug_mem_arbiter
  import debug_mem_arbiter_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] PROT_BASE = ADDR_W'(DEF_PROT_BASE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_set_addr,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_wr,
  input  logic              jtag_rd,
  input  logic [DATA_W-1:0] jtag_wdata,
  input  logic              jtag_clr_ovf,
  output logic [DATA_W-1:0] jtag_rdata,
  output logic              jtag_rdata_valid,
  output logic              jtag_busy,
  output logic              jtag_ovf,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [ADDR_W-1:0] av_address,
  input  logic [DATA_W-1:0] av_writedata,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
`ifdef DEBUG_MEM_ARBITER_WRPROT_EN
  output logic              cpu_wr_err,
`endif
  input  logic [DATA_W-1:0] ram_q
);

  arbState_e r_state;
  arbState_e w_nextState;
  grant_e    r_lastGrant;

  logic [DATA_W-1:0] r_jtagRdata;
  logic              r_jtagRdataValid;

  logic [ADDR_W-1:0] w_jaddr;
  logic              w_jpend;
  logic              w_jopRd;
  logic [DATA_W-1:0] w_jwdata;
  logic              w_ovf;
  logic              w_jtagDone;

  logic w_cpuReq;
  logic w_grantCpu;
  logic w_grantJtag;
  logic w_protHit;

  assign w_cpuReq = av_read | av_write;

`ifdef DEBUG_MEM_ARBITER_WRPROT_EN
  assign w_protHit = (av_address >= PROT_BASE);
`else
  assign w_protHit = 1'b0;
`endif

  debug_mem_jtag_cmd_latch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cmdLatch (
    .clk       (clk),
    .reset     (reset),
    .i_setAddr (jtag_set_addr),
    .i_addr    (jtag_addr),
    .i_wr      (jtag_wr),
    .i_rd      (jtag_rd),
    .i_wdata   (jtag_wdata),
    .i_clrOvf  (jtag_clr_ovf),
    .i_cmdDone (w_jtagDone),
    .o_jaddr   (w_jaddr),
    .o_jpend   (w_jpend),
    .o_jopRd   (w_jopRd),
    .o_jwdata  (w_jwdata),
    .o_ovf     (w_ovf)
  );

  // Grants are only issued from IDLE; a tie goes to whoever did not win last.
  always_comb begin
    w_grantCpu  = 1'b0;
    w_grantJtag = 1'b0;
    if (r_state == IDLE) begin
      if (w_cpuReq && w_jpend) begin
        if (tieWinner(r_lastGrant) == GNT_JTAG) begin
          w_grantJtag = 1'b1;
        end else begin
          w_grantCpu = 1'b1;
        end
      end else if (w_cpuReq) begin
        w_grantCpu = 1'b1;
      end else if (w_jpend) begin
        w_grantJtag = 1'b1;
      end
    end
  end

  // Next state and RAM/Avalon muxing, all driven from the current state and grant.
  always_comb begin
    w_nextState    = r_state;
    w_jtagDone     = 1'b0;
    ram_addr       = '0;
    ram_wdata      = '0;
    ram_we         = 1'b0;
    ram_re         = 1'b0;
    av_readdata    = '0;
    av_waitrequest = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grantCpu) begin
          ram_addr = av_address;
          if (av_write) begin
            ram_wdata = av_writedata;
            ram_we    = ~w_protHit;
          end else begin
            ram_re      = 1'b1;
            w_nextState = CPU_RD;
          end
        end else if (w_grantJtag) begin
          ram_addr = w_jaddr;
          if (w_jopRd) begin
            ram_re      = 1'b1;
            w_nextState = JTAG_RD;
          end else begin
            ram_wdata  = w_jwdata;
            ram_we     = 1'b1;
            w_jtagDone = 1'b1;
          end
        end
      end
      CPU_RD: begin
        av_readdata = ram_q;
        w_nextState = IDLE;
      end
      JTAG_RD: begin
        w_jtagDone  = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    av_waitrequest = w_cpuReq & ~((w_grantCpu & av_write) | (r_state == CPU_RD));
  end

  // FSM state register and round-robin history.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lastGrant <= GNT_CPU;
    end else begin
      r_state <= w_nextState;
      if (w_grantCpu) begin
        r_lastGrant <= GNT_CPU;
      end else if (w_grantJtag) begin
        r_lastGrant <= GNT_JTAG;
      end
    end
  end

  // Capture JTAG read data as it leaves the RAM and flag it for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_jtagRdata      <= '0;
      r_jtagRdataValid <= 1'b0;
    end else begin
      r_jtagRdataValid <= (r_state == JTAG_RD);
      if (r_state == JTAG_RD) begin
        r_jtagRdata <= ram_q;
      end
    end
  end

`ifdef DEBUG_MEM_ARBITER_WRPROT_EN
  logic r_cpuWrErr;

  // Remember any CPU write that hit the protected window until the next reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpuWrErr <= 1'b0;
    end else if (w_grantCpu && av_write && w_protHit) begin
      r_cpuWrErr <= 1'b1;
    end
  end

  assign cpu_wr_err = r_cpuWrErr;
`endif

  assign jtag_rdata       = r_jtagRdata;
  assign jtag_rdata_valid = r_jtagRdataValid;
  assign jtag_busy        = w_jpend;
  assign jtag_ovf         = w_ovf;

endmodule
